calc_alu: RTL and testbench

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/calc_alu_core.sv | 61 ++++++
 rtl/calc_alu.sv | 105 ++++++++++
 tb/tb_calc_alu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared definitions for the calc_alu block: the 6-bit op-code
//             type, the named op-code constants and the decoded control
//             bundle {zx,nx,zy,ny,f,no}.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int OP_W = 6;

    typedef logic [OP_W-1:0] op_t;

    // Op-code bit order, MSB to LSB: zx, nx, zy, ny, f, no
    localparam op_t OP_ZERO  = 6'b101010;
    localparam op_t OP_ONE   = 6'b111111;
    localparam op_t OP_NEG1  = 6'b111010;
    localparam op_t OP_X     = 6'b001100;
    localparam op_t OP_Y     = 6'b110000;
    localparam op_t OP_NOTX  = 6'b001101;
    localparam op_t OP_NOTY  = 6'b110001;
    localparam op_t OP_NEGX  = 6'b001111;
    localparam op_t OP_NEGY  = 6'b110011;
    localparam op_t OP_XP1   = 6'b011111;
    localparam op_t OP_YP1   = 6'b110111;
    localparam op_t OP_XM1   = 6'b001110;
    localparam op_t OP_YM1   = 6'b110010;
    localparam op_t OP_XPY   = 6'b000010;
    localparam op_t OP_XMY   = 6'b010011;
    localparam op_t OP_YMX   = 6'b000111;
    localparam op_t OP_XANDY = 6'b000000;
    localparam op_t OP_XORY  = 6'b010101;

    // Decoded control bundle; field order matches the op-code bit order so
    // a plain cast performs the decode.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

    function automatic ctrl_t decode_op(input op_t op);
        return ctrl_t'(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : calc_alu_core
//  Purpose  : Purely combinational ALU datapath. Pre-conditions each operand
//             (optional zero, then optional invert), combines them with an
//             add or a bitwise AND, then optionally inverts the result.
//  Ports    : x, y  [WIDTH]  operands
//             op    [6]      {zx,nx,zy,ny,f,no}
//             res   [WIDTH]  combinational result
//             ovf   [1]      signed overflow of the add (CALC_OVF_EN only)
//  Config   : CALC_OVF_EN - when defined, the ovf output and logic exist.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_alu_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_t              op,
    output logic [WIDTH-1:0] res
`ifdef CALC_OVF_EN
    ,
    output logic             ovf
`endif
);

    ctrl_t            ctrl;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] r;

    assign ctrl = decode_op(op);

    always_comb begin
        // A select-driven mux, not a mask, so an unknown operand cannot leak
        // through when its zero control is set.
        xa = ctrl.zx ? '0 : x;
        xb = ctrl.nx ? ~xa : xa;
        ya = ctrl.zy ? '0 : y;
        yb = ctrl.ny ? ~ya : ya;
        // Carry-out of the add is intentionally dropped (modulo 2^WIDTH).
        r   = ctrl.f ? (xb + yb) : (xb & yb);
        res = ctrl.no ? ~r : r;
    end

`ifdef CALC_OVF_EN
    // Two's-complement overflow of the add: operands agree in sign but the
    // sum (before the final inversion) does not. Meaningless for AND.
    always_comb begin
        ovf = ctrl.f
            & (xb[WIDTH-1] == yb[WIDTH-1])
            & (r[WIDTH-1]  != xb[WIDTH-1]);
    end
`endif

endmodule
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : calc_alu
//  Purpose  : Registered ALU. Samples operands and a 6-bit control word when
//             in_valid is high and presents the result, zero and negative
//             flags one cycle later with out_valid. Accepts one operation per
//             cycle; there is no back-pressure.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             in_valid   operands/control valid this cycle
//             x, y       [WIDTH] operands
//             zx,nx,zy,ny,f,no  control bits (op code, MSB first)
//             out        [WIDTH] registered result
//             zr         registered flag, out == 0
//             ng         registered flag, out[WIDTH-1]
//             out_valid  out/zr/ng hold a new result this cycle
//             ovf        registered signed overflow (CALC_OVF_EN only)
//  Config   : CALC_OVF_EN - when defined, the ovf port and logic exist.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid
`ifdef CALC_OVF_EN
    ,
    output logic             ovf
`endif
);

    op_t              op;
    logic [WIDTH-1:0] res;

    assign op = {zx, nx, zy, ny, f, no};

`ifdef CALC_OVF_EN
    logic core_ovf;

    calc_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x   (x),
        .y   (y),
        .op  (op),
        .res (res),
        .ovf (core_ovf)
    );
`else
    calc_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x   (x),
        .y   (y),
        .op  (op),
        .res (res)
    );
`endif

    // Result and flags load only on accepted inputs and otherwise hold;
    // out_valid is a one-cycle echo of in_valid. Reset clears everything,
    // which also drops any operation sampled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= res;
                zr  <= (res == '0);
                ng  <= res[WIDTH-1];
            end
        end
    end

`ifdef CALC_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= core_ovf;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_alu
//  Purpose  : Scoreboard bench for calc_alu (WIDTH=16). Stimulus pushes
//             hand-computed expectations; a monitor pops them whenever the
//             DUT raises out_valid.
//  Config   : CALC_OVF_EN - when defined, ovf is also compared.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_alu;
    import calc_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             zr;
        logic             ng;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx, nx, zy, ny, f, no;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             out_valid;
`ifdef CALC_OVF_EN
    logic             ovf;
`endif

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic vld_d;

    calc_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .out_valid (out_valid)
`ifdef CALC_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation; expected zr/ng follow from the expected result.
    task automatic issue(input op_t op, input logic [WIDTH-1:0] xv,
                         input logic [WIDTH-1:0] yv,
                         input logic [WIDTH-1:0] eout, input logic eovf);
        exp_t e;
        in_valid = 1'b1;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = op;
        e.out = eout;
        e.zr  = (eout == '0);
        e.ng  = eout[WIDTH-1];
        e.ovf = eovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: tracks whether a result is due, and checks it on the
    // falling edge, away from the sampling edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_d <= 1'b0;
        else        vld_d <= in_valid;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, vld_d});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got out=0x%0h expected no result", out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out", {48'd0, out}, {48'd0, e.out});
                    chk("zr",  {63'd0, zr},  {63'd0, e.zr});
                    chk("ng",  {63'd0, ng},  {63'd0, e.ng});
`ifdef CALC_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        {zx, nx, zy, ny, f, no} = 6'b000000;

        // Reset state, including across a clock edge
        #12;
        chk("rst_out",       {48'd0, out},       64'h0);
        chk("rst_zr",        {63'd0, zr},        64'h1);
        chk("rst_ng",        {63'd0, ng},        64'h0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'h0);
`ifdef CALC_OVF_EN
        chk("rst_ovf",       {63'd0, ovf},       64'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, back-to-back
        issue(OP_YP1,  'x,       16'h0000, 16'h0001, 1'b0);
        issue(OP_XPY,  16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        issue(OP_XMY,  16'h0005, 16'h0005, 16'h0000, 1'b0);
        issue(OP_ZERO, 16'hABCD, 16'h1234, 16'h0000, 1'b0);
        issue(OP_X,    16'h1234, 16'h00FF, 16'h1234, 1'b0);
        issue(OP_NOTY, 16'h1234, 16'h00FF, 16'hFF00, 1'b0);
        issue(OP_NEG1, 16'h1234, 16'h00FF, 16'hFFFF, 1'b0);
        idle();
        // Result holds while idle
        @(negedge clk);
        chk("hold_out",       {48'd0, out},       64'hFFFF);
        chk("hold_out_valid", {63'd0, out_valid}, 64'h0);
        @(posedge clk);
        #1;

        issue(OP_XANDY, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
        issue(OP_XORY,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0);
        issue(OP_YMX,   16'h0003, 16'h000A, 16'h0007, 1'b0);
        issue(OP_NEGX,  16'h8000, 16'h5555, 16'h8000, 1'b1);
        issue(OP_XM1,   16'h0000, 16'h1111, 16'hFFFF, 1'b0);
        issue(OP_X,     16'h00A5, 'x,       16'h00A5, 1'b0);
        issue(OP_ONE,   16'h1357, 16'h2468, 16'h0001, 1'b0);
        idle();

        // Asynchronous reset between edges after a registered result
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",       {48'd0, out},       64'h0);
        chk("async_rst_zr",        {63'd0, zr},        64'h1);
        chk("async_rst_ng",        {63'd0, ng},        64'h0);
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'h0);
`ifdef CALC_OVF_EN
        chk("async_rst_ovf",       {63'd0, ovf},       64'h0);
`endif
        // Inputs presented during reset are discarded
        in_valid = 1'b1;
        x = 16'hFFFF;
        {zx, nx, zy, ny, f, no} = OP_X;
        repeat (2) @(posedge clk);
        #1;
        chk("in_rst_out",       {48'd0, out},       64'h0);
        chk("in_rst_out_valid", {63'd0, out_valid}, 64'h0);
        in_valid = 1'b0;

        // First edge after release samples normally
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_XP1, 16'h0041, 16'h0000, 16'h0042, 1'b0);
        idle();

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
